// File: rtl/uart_fifo_gen.sv
// Parametrised UART FIFO with 16550 trigger levels, error-tag accounting,
// character-timeout detection and a single-entry 16450 mode.
module uart_fifo_gen #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TO_W   = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic [2:0]                 err_in,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic [2:0]                 err_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overrun,
    output logic                       underrun,
    input  logic [1:0]                 trig_level,
    output logic                       thre_trigger,
    output logic                       err_in_fifo,
    input  logic                       baud_pulse,
    input  logic [TO_W-1:0]            to_char_cycles,
    output logic                       timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W+2:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, waddr;
    logic [CW-1:0]     count_q, count_d, err_cnt_q, err_cnt_d, cap, lvl;
    logic [TO_W-1:0]   timer_q, timer_d;
    logic              en_q, overrun_q, underrun_q;
    logic              flush, do_push, do_pop, err_inc, err_dec;
    logic [DATA_W+2:0] head;

    assign cap   = en ? CW'(DEPTH) : CW'(1);
    assign empty = (count_q == '0);
    assign full  = (count_q == cap);
    assign flush = clr || (en != en_q);

    // A push into a full FIFO is still taken when a pop frees the head slot.
    assign do_push = !flush && push && (!full || (pop && !empty));
    assign do_pop  = !flush && pop && !empty;

    // 16450 mode keeps both pointers parked so the single entry lives at rd_ptr.
    assign waddr = en ? wr_ptr_q : rd_ptr_q;

    assign head    = mem_q[rd_ptr_q];
    assign dout    = empty ? '0 : head[DATA_W-1:0];
    assign err_out = empty ? '0 : head[DATA_W+2:DATA_W];
    assign err_inc = do_push && (err_in != 3'b000);
    assign err_dec = do_pop && (err_out != 3'b000);

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            err_cnt_d = '0;
        end else begin
            if (do_push && en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop && en)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            case ({err_inc, err_dec})
                2'b10:   err_cnt_d = err_cnt_q + CW'(1);
                2'b01:   err_cnt_d = err_cnt_q - CW'(1);
                default: err_cnt_d = err_cnt_q;
            endcase
        end
    end

    // Timer saturates at the compare value, so timeout holds until activity.
    always_comb begin
        timer_d = timer_q;
        if (flush || do_push || pop || empty)
            timer_d = '0;
        else if (baud_pulse && (timer_q != to_char_cycles))
            timer_d = timer_q + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            err_cnt_q  <= '0;
            timer_q    <= '0;
            en_q       <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            err_cnt_q  <= err_cnt_d;
            timer_q    <= timer_d;
            en_q       <= en;
            overrun_q  <= !flush && push && full && !pop;
            underrun_q <= !flush && pop && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[waddr] <= {err_in, din};
    end

    always_comb begin
        lvl = CW'(1);
        case (trig_level)
            2'b00: lvl = CW'(1);
            2'b01: lvl = CW'(DEPTH / 4);
            2'b10: lvl = CW'(DEPTH / 2);
            2'b11: lvl = CW'(DEPTH - 2);
        endcase
    end

    assign count        = count_q;
    assign overrun      = overrun_q;
    assign underrun     = underrun_q;
    assign thre_trigger = (count_q >= lvl);
    assign err_in_fifo  = (err_cnt_q != '0);
    assign timeout      = !empty && (to_char_cycles != '0) && (timer_q == to_char_cycles);
endmodule

// File: tb/tb_uart_fifo_gen.sv
// Directed bench for uart_fifo_gen: scoreboard queue fed by stimulus, drained
// by a monitor that checks the head every time a pop is presented.
module tb_uart_fifo_gen;
    logic       clk = 0, rst = 1, en = 0, clr = 0, push = 0, pop = 0, baud_pulse = 0;
    logic [7:0] din = 0;
    logic [2:0] err_in = 0;
    logic [1:0] trig_level = 0;
    logic [9:0] to_char_cycles = 0;
    logic [7:0] dout;
    logic [2:0] err_out;
    logic [4:0] count;
    logic       empty, full, overrun, underrun, thre_trigger, err_in_fifo, timeout;

    int n_vec = 0, n_bad = 0;
    logic [10:0] exp_q[$];

    uart_fifo_gen #(.DATA_W(8), .DEPTH(16), .TO_W(10)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .push(push), .din(din),
        .err_in(err_in), .pop(pop), .dout(dout), .err_out(err_out), .count(count),
        .empty(empty), .full(full), .overrun(overrun), .underrun(underrun),
        .trig_level(trig_level), .thre_trigger(thre_trigger), .err_in_fifo(err_in_fifo),
        .baud_pulse(baud_pulse), .to_char_cycles(to_char_cycles), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Monitor: inputs settle after posedge, so at negedge the upcoming pop is known.
    always @(negedge clk) begin
        if (rst && pop && !empty) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_data: dout=%h err=%b popped with nothing expected", dout, err_out);
            end else begin
                if ({err_out, dout} !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL pop_data: got err=%b dout=%h, want err=%b dout=%h",
                             err_out, dout, exp_q[0][10:8], exp_q[0][7:0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input logic [2:0] e, input bit accepted);
        push = 1; din = d; err_in = e;
        if (accepted) exp_q.push_back({e, d});
        tick();
        push = 0;
    endtask

    task automatic rd();
        pop = 1;
        tick();
        pop = 0;
    endtask

    initial begin
        #1 rst = 0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_dout", dout, 0);
        chk("rst_flags", {overrun, underrun, err_in_fifo, timeout, thre_trigger}, 0);
        en = 1;
        tick();
        rst = 1;
        tick();
        tick();

        // Fill to 16 checking trigger thresholds on the way up.
        trig_level = 2'b10;
        for (int i = 1; i <= 16; i++) begin
            wr(8'(i), 3'b000, 1);
            if (i == 7)  chk("thre_l10_c7", thre_trigger, 0);
            if (i == 8)  chk("thre_l10_c8", thre_trigger, 1);
            if (i == 13) begin trig_level = 2'b11; #1 chk("thre_l11_c13", thre_trigger, 0); end
            if (i == 14) chk("thre_l11_c14", thre_trigger, 1);
        end
        chk("full_flag", full, 1);
        chk("full_count", count, 16);
        wr(8'hAA, 3'b000, 0);
        chk("overrun_pulse", overrun, 1);
        chk("overrun_count", count, 16);
        tick();
        chk("overrun_1cyc", overrun, 0);

        // Push and pop together at full: no overrun, count held.
        push = 1; pop = 1; din = 8'hBB; exp_q.push_back({3'b000, 8'hBB});
        tick();
        push = 0; pop = 0;
        chk("pp_full_count", count, 16);
        chk("pp_full_ovr", overrun, 0);

        trig_level = 2'b10;
        for (int i = 0; i < 8; i++) rd();
        chk("thre_c8", thre_trigger, 1);
        rd();
        chk("thre_c7", thre_trigger, 0);
        for (int i = 0; i < 7; i++) rd();
        chk("drain_empty", empty, 1);
        chk("drain_dout", dout, 0);

        // Pop while empty together with a push.
        push = 1; pop = 1; din = 8'h77; exp_q.push_back({3'b000, 8'h77});
        tick();
        push = 0; pop = 0;
        chk("underrun_pulse", underrun, 1);
        chk("underrun_count", count, 1);
        chk("underrun_dout", dout, 8'h77);
        rd();
        chk("underrun_1cyc", underrun, 0);

        // Error tag accounting.
        wr(8'h55, 3'b010, 1);
        wr(8'h66, 3'b000, 1);
        chk("err_fifo_set", err_in_fifo, 1);
        chk("err_head_dout", dout, 8'h55);
        chk("err_head_tag", err_out, 3'b010);
        rd();
        chk("err_fifo_clr", err_in_fifo, 0);
        chk("err_next_dout", dout, 8'h66);
        rd();

        // Character timeout.
        to_char_cycles = 10'd40;
        wr(8'h99, 3'b000, 1);
        for (int i = 1; i <= 40; i++) begin
            baud_pulse = 1; tick(); baud_pulse = 0; tick();
            if (i == 39) chk("to_39", timeout, 0);
        end
        chk("to_40", timeout, 1);
        baud_pulse = 1; tick(); baud_pulse = 0; tick();
        chk("to_held", timeout, 1);
        rd();
        chk("to_pop", timeout, 0);
        to_char_cycles = 0;

        // 16450 mode.
        en = 0;
        tick();
        wr(8'h11, 3'b000, 1);
        wr(8'h22, 3'b000, 0);
        chk("m16450_ovr", overrun, 1);
        chk("m16450_dout", dout, 8'h11);
        chk("m16450_full", full, 1);
        en = 1;
        tick();
        exp_q.delete();
        chk("en_flush_empty", empty, 1);
        for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i), 3'b000, 1);
        chk("refill_count", count, 5);
        #2 rst = 0;
        #1;
        exp_q.delete();
        chk("async_rst_count", count, 0);
        chk("async_rst_empty", empty, 1);
        tick();
        rst = 1;
        tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
